pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries an opaque DATA_W-bit payload plus a halt tag across a valid/ready handshake.
- Optional 2-entry skid buffer gives registered backpressure; also provides synchronous flush, sticky halt retirement and saturating stall/bubble counters for the CPU tracker.
- Instantiated once per stage boundary in the datapath.

Parameters:
- DATA_W, 128, payload width in bits (packed stage bundle: control, result, store data, tracker fields).
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall and bubble counters.

Ports:
- CLK  in  1  clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halt  in  1  entry is a halt instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  DATA_W  head payload.
- out_halt  out  1  head entry halt tag.
- flush  in  1  synchronous squash of all held entries.
- halt_done  out  1  sticky; set when a halt entry retires from the output.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and halt_done=0, saturating.

Behaviour:
- Clock and reset: single clock CLK. Reset nRST is asynchronous, active-low. Reset values: state EMPTY, all data registers 0, out_valid 0, out_halt 0, halt_done 0, occupancy 0, both counters 0. in_ready after reset is 1.
- Handshake events: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. in_data is sampled only on in_fire.
- Payload rules: out_data and out_halt come directly from the main register with 0-cycle output latency. An accepted entry is visible at the output on the next cycle (1-cycle latency).
- States (SKID_EN=1) are EMPTY, FULL and SKID. Transitions:
  - EMPTY: in_fire -> FULL, main <= in.
  - FULL: in_fire & !out_fire -> SKID, skid <= in. out_fire & !in_fire -> EMPTY. Both fire -> stay FULL, main <= in.
  - SKID: out_fire -> FULL, main <= skid. in_fire is impossible in SKID.
- in_ready (SKID_EN=1) is a registered signal, equal to 1 whenever state != SKID. It has no combinational path from out_ready.
- SKID_EN=0: the SKID state is never entered. in_ready = !out_valid | out_ready, combinational. Simultaneous in_fire and out_fire replaces main.
- Flush: synchronous and has priority over every other event. Next state is EMPTY; out_valid goes to 0 the next cycle. An in_fire in the flush cycle is discarded. A head entry that out_fires in the flush cycle counts as retired.
- Halt: halt_done is set on out_fire with out_halt=1.
  - From the next cycle onward, in_ready=0 and out_valid=0 until reset.
  - Entries behind the halt are dropped.
  - flush does not clear halt_done.
- Counters: each counter increments by 1 per qualifying cycle and holds at 2^CNT_W-1 (no wrap). Neither counter is cleared by flush.
- occupancy encoding: EMPTY=0, FULL=1, SKID=2.
- Reset mid-operation: all state returns to reset values immediately; held entries are lost.

Decomposition:
- Package pipe_reg_pkg holds:
  - the state enum typedef (EMPTY, FULL, SKID);
  - a saturate-max helper constant.
  - The stage-specific packed payload structs also live here, so they can be cast into and out of DATA_W.
- One sub-module, sat_counter (parameter CNT_W; ports CLK, nRST, inc, count), is instantiated twice.

Test Plan:
- Streaming: in_valid=1 and out_ready=1 for 4 cycles with data 0x1..0x4 -> out_data 0x1..0x4 on consecutive cycles starting 1 cycle later; occupancy 1 throughout; stall_cnt=0.
- Backpressure: deassert out_ready while two entries 0xA, 0xB arrive -> occupancy=2, in_ready=0 the next cycle, stall_cnt increments each held cycle. Reassert out_ready -> 0xA then 0xB delivered in order, none lost.
- Flush in SKID with in_valid=1 and data 0xC -> the following cycle out_valid=0, occupancy=0; 0xC never appears at the output.
- Halt: entries 0x5 (halt=1) and 0x6 -> after 0x5 retires, halt_done=1, in_ready=0, 0x6 never emitted; bubble_cnt frozen.
- Saturation with CNT_W=4: stall for 20 cycles -> stall_cnt=15 and stays 15.
- Reset: assert nRST low asynchronously mid-SKID -> all outputs at reset values without waiting for a CLK edge. Repeat the streaming scenario with SKID_EN=0 -> identical data order with combinational in_ready.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// Shared types for the reusable pipeline-stage register: handshake state,
// counter saturation constant and the per-stage payload bundles.
package pipe_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   // Counters up to this width saturate at the low CNT_W bits of this constant.
   localparam int SAT_MAX_W = 64;
   localparam logic [SAT_MAX_W-1:0] SAT_ALL_ONES = '1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [63:0] tracker;
   } ifid_t;

   typedef struct packed {
      logic [15:0] ctrl;
      logic [31:0] rsData;
      logic [31:0] rtData;
      logic [47:0] tracker;
   } idex_t;

   typedef struct packed {
      logic [15:0] ctrl;
      logic [31:0] result;
      logic [31:0] storeData;
      logic [47:0] tracker;
   } exmem_t;

   typedef struct packed {
      logic [15:0] ctrl;
      logic [31:0] result;
      logic [31:0] loadData;
      logic [47:0] tracker;
   } memwb_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments once per qualifying cycle and holds at its
// maximum value instead of wrapping.
module sat_counter
   import pipe_reg_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = SAT_ALL_ONES[CNT_W-1:0];

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with optional 2-entry skid buffer, synchronous
// flush, sticky halt retirement and saturating stall/bubble counters.
module pipe_skid_reg
   import pipe_reg_pkg::*;
#(
   parameter int DATA_W  = 128,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_halt,
   input  logic              flush,
   output logic              halt_done,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] mainData_q, mainData_d;
   logic [DATA_W-1:0] skidData_q, skidData_d;
   logic              mainHalt_q, mainHalt_d;
   logic              skidHalt_q, skidHalt_d;
   logic              haltDone_q, haltDone_d;
   logic              inReady_q, inReady_d;
   logic              inReadyInt;
   logic              outValidInt;
   logic              inFire;
   logic              outFire;
   logic              haltRetire;

   // Once a halt has retired the stage goes permanently quiet until reset.
   assign outValidInt = (state_q != EMPTY) && !haltDone_q;

   generate
      if (SKID_EN != 0) begin : gSkid
         assign inReadyInt = inReady_q;
      end else begin : gNoSkid
         assign inReadyInt = (!outValidInt || out_ready) && !haltDone_q;
      end
   endgenerate

   assign inFire     = in_valid && inReadyInt;
   assign outFire    = outValidInt && out_ready;
   assign haltRetire = outFire && mainHalt_q;

   always_comb begin
      state_d    = state_q;
      mainData_d = mainData_q;
      mainHalt_d = mainHalt_q;
      skidData_d = skidData_q;
      skidHalt_d = skidHalt_q;
      haltDone_d = haltDone_q || haltRetire;
      case (state_q)
         EMPTY: begin
            if (inFire) begin
               state_d    = FULL;
               mainData_d = in_data;
               mainHalt_d = in_halt;
            end
         end
         FULL: begin
            if (inFire && outFire) begin
               mainData_d = in_data;
               mainHalt_d = in_halt;
            end else if (inFire && (SKID_EN != 0)) begin
               state_d    = SKID;
               skidData_d = in_data;
               skidHalt_d = in_halt;
            end else if (outFire) begin
               state_d = EMPTY;
            end
         end
         SKID: begin
            if (outFire) begin
               state_d    = FULL;
               mainData_d = skidData_q;
               mainHalt_d = skidHalt_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush and halt retirement both discard everything still held or arriving.
      if (flush || haltRetire) begin
         state_d = EMPTY;
      end
      inReady_d = (state_d != SKID) && !haltDone_d;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= EMPTY;
         mainData_q <= '0;
         mainHalt_q <= 1'b0;
         skidData_q <= '0;
         skidHalt_q <= 1'b0;
         haltDone_q <= 1'b0;
         inReady_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         mainData_q <= mainData_d;
         mainHalt_q <= mainHalt_d;
         skidData_q <= skidData_d;
         skidHalt_q <= skidHalt_d;
         haltDone_q <= haltDone_d;
         inReady_q  <= inReady_d;
      end
   end

   assign in_ready  = inReadyInt;
   assign out_valid = outValidInt;
   assign out_data  = mainData_q;
   assign out_halt  = mainHalt_q;
   assign halt_done = haltDone_q;
   assign occupancy = state_q;

   sat_counter #(.CNT_W(CNT_W)) uStallCnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (outValidInt && !out_ready),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uBubbleCnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (!outValidInt && !haltDone_q),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a skid instance with 4-bit counters and
// a single-entry instance, each with its own expected-output queue and monitor.
module tb_pipe_skid_reg;

   logic        clk;
   logic        rstN;

   logic        aInValid, aInReady, aInHalt, aOutValid, aOutReady, aOutHalt;
   logic        aFlush, aHaltDone;
   logic [15:0] aInData, aOutData;
   logic [1:0]  aOcc;
   logic [3:0]  aStall, aBubble;

   logic        bInValid, bInReady, bInHalt, bOutValid, bOutReady, bOutHalt;
   logic        bFlush, bHaltDone;
   logic [15:0] bInData, bOutData;
   logic [1:0]  bOcc;
   logic [15:0] bStall, bBubble;

   logic [16:0] aExpQ[$];
   logic [16:0] bExpQ[$];
   logic [16:0] aExp, bExp;

   int errors;
   int checks;

   pipe_skid_reg #(.DATA_W(16), .SKID_EN(1), .CNT_W(4)) dutA (
      .CLK(clk), .nRST(rstN),
      .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_halt(aInHalt),
      .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .out_halt(aOutHalt),
      .flush(aFlush), .halt_done(aHaltDone), .occupancy(aOcc),
      .stall_cnt(aStall), .bubble_cnt(aBubble)
   );

   pipe_skid_reg #(.DATA_W(16), .SKID_EN(0), .CNT_W(16)) dutB (
      .CLK(clk), .nRST(rstN),
      .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_halt(bInHalt),
      .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .out_halt(bOutHalt),
      .flush(bFlush), .halt_done(bHaltDone), .occupancy(bOcc),
      .stall_cnt(bStall), .bubble_cnt(bBubble)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exceeded, required $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic toB, input logic [15:0] d, input logic h,
                                input logic expectOut);
      if (toB) begin
         bInValid = 1'b1;
         bInData  = d;
         bInHalt  = h;
         if (expectOut) bExpQ.push_back({h, d});
      end else begin
         aInValid = 1'b1;
         aInData  = d;
         aInHalt  = h;
         if (expectOut) aExpQ.push_back({h, d});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitors: every output handshake must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rstN && aOutValid && aOutReady) begin
            if (aExpQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL aUnexpected: got data=0x%0h halt=%0b, required no output",
                        aOutData, aOutHalt);
            end else begin
               aExp = aExpQ.pop_front();
               checkOutput("aOutEntry", 32'({aOutHalt, aOutData}), 32'(aExp));
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rstN && bOutValid && bOutReady) begin
            if (bExpQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL bUnexpected: got data=0x%0h halt=%0b, required no output",
                        bOutData, bOutHalt);
            end else begin
               bExp = bExpQ.pop_front();
               checkOutput("bOutEntry", 32'({bOutHalt, bOutData}), 32'(bExp));
            end
         end
      end
   end

   // Directed sequence; inputs change 1 time unit after a rising edge,
   // register outputs are checked on the falling edge.
   initial begin
      errors    = 0;
      checks    = 0;
      rstN      = 1'b0;
      aInValid  = 1'b0; aInData = '0; aInHalt = 1'b0; aOutReady = 1'b0; aFlush = 1'b0;
      bInValid  = 1'b0; bInData = '0; bInHalt = 1'b0; bOutReady = 1'b1; bFlush = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstInReady", 32'(aInReady), 1);
      checkOutput("rstOutValid", 32'(aOutValid), 0);
      checkOutput("rstOcc", 32'(aOcc), 0);
      checkOutput("rstHaltDone", 32'(aHaltDone), 0);
      checkOutput("rstStall", 32'(aStall), 0);
      checkOutput("rstBubble", 32'(aBubble), 0);
      checkOutput("rstOutData", 32'(aOutData), 0);
      checkOutput("rstOutHalt", 32'(aOutHalt), 0);

      // Streaming 0x1..0x4 with the sink always ready.
      tick();
      rstN      = 1'b1;
      aOutReady = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b0, 16'(i), 1'b0, 1'b1);
         @(negedge clk);
         if (i == 1) begin
            checkOutput("streamLatency", 32'(aOutValid), 0);
         end else begin
            checkOutput("streamOcc", 32'(aOcc), 1);
            checkOutput("streamInReady", 32'(aInReady), 1);
         end
         tick();
      end
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("streamLastOcc", 32'(aOcc), 1);
      tick();
      @(negedge clk);
      checkOutput("streamDrainOcc", 32'(aOcc), 0);
      checkOutput("streamStall", 32'(aStall), 0);

      // Backpressure: 0xA and 0xB arrive while the sink is stalled.
      tick();
      aOutReady = 1'b0;
      applyStimulus(1'b0, 16'h000A, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 16'h000B, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("bpOccOne", 32'(aOcc), 1);
      checkOutput("bpReadyOne", 32'(aInReady), 1);
      tick();
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("bpOccTwo", 32'(aOcc), 2);
      checkOutput("bpReadyLow", 32'(aInReady), 0);
      checkOutput("bpStallOne", 32'(aStall), 1);
      tick();
      aOutReady = 1'b1;
      @(negedge clk);
      checkOutput("bpStallTwo", 32'(aStall), 2);
      checkOutput("bpHeadA", 32'(aOutData), 32'h000A);
      tick();
      @(negedge clk);
      checkOutput("bpOccBack", 32'(aOcc), 1);
      checkOutput("bpReadyBack", 32'(aInReady), 1);
      tick();
      @(negedge clk);
      checkOutput("bpOccEmpty", 32'(aOcc), 0);
      checkOutput("bpStallHeld", 32'(aStall), 2);

      // Flush from SKID with 0xC offered, then flush discarding an in_fire of 0xD.
      tick();
      aOutReady = 1'b0;
      applyStimulus(1'b0, 16'h0007, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0008, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h000C, 1'b0, 1'b0);
      aFlush = 1'b1;
      @(negedge clk);
      checkOutput("flushPreOcc", 32'(aOcc), 2);
      tick();
      applyStimulus(1'b0, 16'h000D, 1'b0, 1'b0);
      aOutReady = 1'b1;
      @(negedge clk);
      checkOutput("flushOutValid", 32'(aOutValid), 0);
      checkOutput("flushOcc", 32'(aOcc), 0);
      checkOutput("flushInReady", 32'(aInReady), 1);
      tick();
      aInValid = 1'b0;
      aFlush   = 1'b0;
      @(negedge clk);
      checkOutput("flushDiscardValid", 32'(aOutValid), 0);
      checkOutput("flushStall", 32'(aStall), 4);

      // Stall counter saturation at 15 with a 4-bit counter.
      tick();
      aOutReady = 1'b0;
      applyStimulus(1'b0, 16'h0009, 1'b0, 1'b1);
      tick();
      aInValid = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      checkOutput("satClimb", 32'(aStall), 14);
      repeat (10) tick();
      @(negedge clk);
      checkOutput("satReached", 32'(aStall), 15);
      tick();
      @(negedge clk);
      checkOutput("satHold", 32'(aStall), 15);
      tick();
      aOutReady = 1'b1;
      @(negedge clk);
      tick();

      // Asynchronous reset in the middle of a SKID cycle.
      aOutReady = 1'b0;
      applyStimulus(1'b0, 16'h0011, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0012, 1'b0, 1'b0);
      tick();
      aInValid = 1'b0;
      #2;
      checkOutput("arstPreOcc", 32'(aOcc), 2);
      rstN = 1'b0;
      #1;
      checkOutput("arstOutValid", 32'(aOutValid), 0);
      checkOutput("arstOcc", 32'(aOcc), 0);
      checkOutput("arstInReady", 32'(aInReady), 1);
      checkOutput("arstStall", 32'(aStall), 0);
      checkOutput("arstBubble", 32'(aBubble), 0);
      checkOutput("arstHaltDone", 32'(aHaltDone), 0);
      checkOutput("arstOutData", 32'(aOutData), 0);

      // Halt: 0x5 tagged halt retires, 0x6 behind it must be dropped.
      aOutReady = 1'b1;
      applyStimulus(1'b0, 16'h0005, 1'b1, 1'b1);
      tick();
      rstN = 1'b1;
      tick();
      applyStimulus(1'b0, 16'h0006, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("haltHeadTag", 32'(aOutHalt), 1);
      tick();
      @(negedge clk);
      checkOutput("haltDoneSet", 32'(aHaltDone), 1);
      checkOutput("haltInReady", 32'(aInReady), 0);
      checkOutput("haltOutValid", 32'(aOutValid), 0);
      checkOutput("haltBubble", 32'(aBubble), 1);
      tick();
      aFlush = 1'b1;
      tick();
      aFlush = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      checkOutput("haltSticky", 32'(aHaltDone), 1);
      checkOutput("haltStillQuiet", 32'(aOutValid), 0);
      checkOutput("haltStillBlocked", 32'(aInReady), 0);
      checkOutput("haltBubbleFrozen", 32'(aBubble), 1);
      aInValid = 1'b0;

      // Single-entry instance: same streaming order, combinational in_ready.
      tick();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 16'(i), 1'b0, 1'b1);
         @(negedge clk);
         if (i == 1) begin
            checkOutput("bStreamLatency", 32'(bOutValid), 0);
         end else begin
            checkOutput("bStreamOcc", 32'(bOcc), 1);
            checkOutput("bStreamInReady", 32'(bInReady), 1);
         end
         tick();
      end
      bInValid = 1'b0;
      @(negedge clk);
      checkOutput("bStreamLastOcc", 32'(bOcc), 1);
      tick();
      applyStimulus(1'b1, 16'h0021, 1'b0, 1'b1);
      tick();
      bOutReady = 1'b0;
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b1);
      #1;
      checkOutput("bCombLow", 32'(bInReady), 0);
      bOutReady = 1'b1;
      #1;
      checkOutput("bCombHigh", 32'(bInReady), 1);
      @(negedge clk);
      tick();
      bInValid = 1'b0;
      @(negedge clk);
      checkOutput("bReplaceOcc", 32'(bOcc), 1);
      checkOutput("bReplaceData", 32'(bOutData), 32'h0022);
      tick();
      @(negedge clk);
      checkOutput("bDrainOcc", 32'(bOcc), 0);
      checkOutput("bStall", 32'(bStall), 0);

      checkOutput("aDrained", 32'(aExpQ.size()), 0);
      checkOutput("bDrained", 32'(bExpQ.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
